// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one synchronous-read data memory port between the CPU load/store path
// and a host port (program/data loading, debug readback). Every access walks a
// fixed IDLE -> ISSUE -> RESP -> ACK sequence. The ACK cycle also arbitrates,
// so alternating traffic sustains one access every three cycles.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/addr/wdata/wren        CPU request; wren == 0 means read
//   cpu_rdata/ack/err/stall        CPU response; stall = req & ~ack
//   host_*                         same as the CPU port
//   mem_addr/wdata/wren/rd_en      registered memory command, valid in ISSUE
//   mem_rdata                      memory read data, one cycle after rd_en
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    // CPU port
    input  logic              cpu_req,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic [3:0]        cpu_wren,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    // Host port
    input  logic              host_req,
    input  logic [AWIDTH-1:0] host_addr,
    input  logic [DWIDTH-1:0] host_wdata,
    input  logic [3:0]        host_wren,
    output logic [DWIDTH-1:0] host_rdata,
    output logic              host_ack,
    output logic              host_err,
    // Memory port
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [3:0]        mem_wren,
    output logic              mem_rd_en,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    // Word index beyond the implemented depth; byte offset bits are ignored.
    function automatic logic addr_out_of_range(input logic [AWIDTH-1:0] addr);
        logic [AWIDTH-1:0] word_idx;
        word_idx = {2'b00, addr[AWIDTH-1:2]};
        return (word_idx >= AWIDTH'(DEPTH_WORDS));
    endfunction

    // FSM and registered outputs
    state_e            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              is_read_q;
    logic              oor_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic [3:0]        mem_wren_q;
    logic              mem_rd_en_q;
    logic [DWIDTH-1:0] cpu_rdata_q;
    logic [DWIDTH-1:0] host_rdata_q;
    logic              cpu_ack_q;
    logic              host_ack_q;
    logic              cpu_err_q;
    logic              host_err_q;

    // Arbitration results (combinational)
    logic              cpu_elig;
    logic              host_elig;
    logic              arb_valid;
    logic              arb_host;
    logic              load_d;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic [3:0]        sel_wren;
    logic              sel_oor;
    logic              sel_read;

    // Arbitration: in ACK the just-acked requester sits out one cycle, so a
    // held request only becomes eligible again from the following cycle.
    always_comb begin
        cpu_elig  = 1'b0;
        host_elig = 1'b0;
        arb_valid = 1'b0;
        arb_host  = 1'b0;
        load_d    = 1'b0;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        sel_wren  = cpu_wren;

        if (state_q == ST_ACK) begin
            cpu_elig  = cpu_req  & (grant_q != GRANT_CPU);
            host_elig = host_req & (grant_q != GRANT_HOST);
        end else begin
            cpu_elig  = cpu_req;
            host_elig = host_req;
        end

        arb_valid = cpu_elig | host_elig;
        // On a tie the port that was not served last wins.
        arb_host  = host_elig & (~cpu_elig | (last_grant_q == GRANT_CPU));

        if ((state_q == ST_IDLE) || (state_q == ST_ACK)) begin
            load_d = arb_valid;
        end else begin
            load_d = 1'b0;
        end

        if (arb_host) begin
            sel_addr  = host_addr;
            sel_wdata = host_wdata;
            sel_wren  = host_wren;
        end else begin
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
            sel_wren  = cpu_wren;
        end

        sel_oor  = addr_out_of_range(sel_addr);
        sel_read = (sel_wren == 4'b0000);
    end

    // Access sequencer, memory command registers and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_CPU;
            last_grant_q <= GRANT_HOST;
            is_read_q    <= 1'b0;
            oor_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wren_q   <= 4'b0000;
            mem_rd_en_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_err_q    <= 1'b0;
            host_err_q   <= 1'b0;
        end else begin
            // Acks and errors are single-cycle pulses.
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            cpu_err_q  <= 1'b0;
            host_err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_ISSUE: begin
                    // The memory consumed the command at this edge.
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_wren_q  <= 4'b0000;
                    mem_rd_en_q <= 1'b0;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Out-of-range reads never touched memory, so rdata holds.
                    if (is_read_q && !oor_q) begin
                        if (grant_q == GRANT_HOST) begin
                            host_rdata_q <= mem_rdata;
                        end else begin
                            cpu_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cpu_rdata_q  <= cpu_rdata_q;
                        host_rdata_q <= host_rdata_q;
                    end
                    if (grant_q == GRANT_HOST) begin
                        host_ack_q <= 1'b1;
                        host_err_q <= oor_q;
                    end else begin
                        cpu_ack_q <= 1'b1;
                        cpu_err_q <= oor_q;
                    end
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    last_grant_q <= grant_q;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Grant: latch the winner's fields; overrides the ACK -> IDLE move.
            if (load_d) begin
                state_q     <= ST_ISSUE;
                grant_q     <= arb_host;
                is_read_q   <= sel_read;
                oor_q       <= sel_oor;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                mem_wren_q  <= sel_oor ? 4'b0000 : sel_wren;
                mem_rd_en_q <= ~sel_oor & sel_read;
            end else begin
                grant_q <= grant_q;
            end
        end
    end

    // Reset in the ACK cycle suppresses the pulse already on the register.
    assign cpu_ack    = cpu_ack_q  & ~rst;
    assign host_ack   = host_ack_q & ~rst;
    assign cpu_err    = cpu_err_q  & ~rst;
    assign host_err   = host_err_q & ~rst;
    assign cpu_stall  = cpu_req & ~cpu_ack;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wren   = mem_wren_q;
    assign mem_rd_en  = mem_rd_en_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single data memory port between the CPU datapath (load/store path) and a host port used for program/data loading and debug readback. It sequences each access through a fixed issue/response state machine, alternates grants round-robin, and returns a stall to the CPU while its access is pending. It sits between `cpu` and `data_memory`, which is converted to a synchronous-read RAM with one-cycle read latency.

## Interface
- `AWIDTH`, 32, address width of all ports.
- `DWIDTH`, 32, data width of all ports.
- `DEPTH_WORDS`, 1024, implemented memory words; accesses at word index ≥ DEPTH_WORDS are errors.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held with fields stable until `cpu_ack`.
- `cpu_addr`  in  AWIDTH  CPU byte address.
- `cpu_wdata`  in  DWIDTH  CPU store data.
- `cpu_wren`  in  4  byte write enables; 0 = read.
- `cpu_rdata`  out  DWIDTH  CPU load data, valid with `cpu_ack` for reads.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  valid with `cpu_ack`; out-of-range access.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational.
- `host_req`, `host_addr`, `host_wdata`, `host_wren`, `host_rdata`, `host_ack`, `host_err`  same widths and rules as the CPU equivalents.
- `mem_addr`  out  AWIDTH  registered memory address.
- `mem_wdata`  out  DWIDTH  registered write data.
- `mem_wren`  out  4  registered byte enables; memory writes at the end of the ISSUE cycle.
- `mem_rd_en`  out  1  registered read strobe.
- `mem_rdata`  in  DWIDTH  read data, valid the cycle after `mem_rd_en`.

## Operation
- States: IDLE, ISSUE, RESP, ACK. `grant` (0 = CPU, 1 = host) and `last_grant` are registered.
- IDLE: arbitrate over eligible requests and latch the winner's addr/wdata/wren into the `mem_*` registers, then go to ISSUE. With no request, stay in IDLE.
- Arbitration: with one request, it wins. With both, the requester not equal to `last_grant` wins. `last_grant` resets to host, so the CPU wins the first tie.
- Range check: word index = addr[AWIDTH-1:2]. If the index is ≥ DEPTH_WORDS, drive `mem_wren`=0 and `mem_rd_en`=0 for this access and set the error flag. The FSM still walks ISSUE/RESP/ACK.
- Alignment: addr[1:0] is ignored. The memory is word-addressed via the byte-enable lanes.
- ISSUE: `mem_*` are valid for exactly this cycle and are cleared to 0 at the next edge.
- RESP: capture `mem_rdata` into the granted port's rdata register (reads only). Writes leave rdata unchanged.
- ACK: pulse the granted `*_ack` and update `last_grant`. `*_err` is high only with an ack when the range check failed.
- ACK also arbitrates exactly like IDLE, excluding the just-acked requester's `req` this cycle. If the other port is requesting, go straight to ISSUE; otherwise go to IDLE.
- Requester rule: drop `req` the cycle after ack, or keep it high to request a new access (eligible from the following cycle).
- `*_rdata` holds its value until the next read completes on that port.
- Request fields are sampled only at grant. Changes afterwards are ignored.

## Timing
- Reset: state=IDLE, `last_grant`=host; all `mem_*`, acks, errs and rdata = 0. `cpu_stall` follows `cpu_req`.
- Latency: req seen in IDLE at cycle T; ISSUE at T+1; RESP at T+2; ack at T+3.
- Back-to-back alternating traffic: one access per 3 cycles (ACK overlaps arbitration).
- `rst` asserted during ISSUE: the write/read already on the `mem_*` registers this cycle still reaches memory. There is no ack; the FSM returns to IDLE. Requesters must re-request.
- `rst` during RESP or ACK: the ack is suppressed and the transaction is lost.
- A request arriving during ISSUE or RESP waits; no state is disturbed.

## Test plan
- Single CPU read: preload word 5 = 0xDEADBEEF; `cpu_req` with addr 0x14, wren 0 at T -> `mem_rd_en` at T+1, `cpu_ack` and `cpu_rdata`=0xDEADBEEF at T+3, `cpu_stall` high T..T+2.
- Byte write: CPU wren 4'b0010, wdata 0x0000AB00 to addr 0x8 over a word holding 0x11223344 -> readback 0x1122AB44, `cpu_err`=0.
- Contention: both requesting continuously from reset -> grant order CPU, host, CPU, host; acks at T+3, T+6, T+9, T+12.
- Out of range: host read at word DEPTH_WORDS -> no `mem_rd_en`/`mem_wren`, `host_ack` and `host_err` at T+3, `host_rdata` unchanged.
- Reset in ISSUE: CPU write of 0x55 to word 2, `rst` high in the ISSUE cycle -> memory word 2 = 0x55, no `cpu_ack`; after reset, the FSM is in IDLE with all outputs 0.
